// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the memory access unit (master) and the memory system (slave).
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: alignment check, bus handshake FSM with pipeline stall,
// store lane steering, load extraction and a sticky bus-wait timeout flag.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [2:0]  memopM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        pipe_stall,
  output logic        stallM,
  output logic [31:0] readdataM,
  output logic        adelM,
  output logic        adesM,
  output logic        bus_err,
  mem_access_unit_if.master dbus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] captured_q, captured_d;
  logic [31:0] readdata_q, readdata_d;
  logic        bus_err_q, bus_err_d;

  logic        is_word, is_half, aligned, valid;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        req, stall, count_en, fresh;

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = {16'h0000, h};
      3'b011:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      default: load_extract = w;
    endcase
  endfunction

  always_comb begin
    is_word = (memopM == 3'b000);
    is_half = (memopM == 3'b001) || (memopM == 3'b010);
    aligned = is_word ? (aluoutM[1:0] == 2'b00) : (is_half ? ~aluoutM[0] : 1'b1);
    size    = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    valid   = memenM & ~flushM & aligned;
    adelM   = memenM & ~flushM & ~aligned & ~memwriteM;
    adesM   = memenM & ~flushM & ~aligned & memwriteM;
    case (size)
      2'd2: begin
        wdata = writedataM;
        wstrb = 4'b1111;
      end
      2'd1: begin
        wdata = {2{writedataM[15:0]}};
        wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = {4{writedataM[7:0]}};
        wstrb = 4'b0001 << aluoutM[1:0];
      end
    endcase
    if (!memwriteM) wstrb = '0;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req        = 1'b0;
    stall      = 1'b0;
    count_en   = 1'b0;
    fresh      = 1'b0;
    captured_d = captured_q;
    case (state_q)
      S_IDLE: begin
        req   = valid;
        stall = valid;
        if (valid) begin
          state_d    = dbus.data_addr_ok ? S_WAIT : S_REQ;
          wait_cnt_d = '0;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // Flush withdraws the request in the same cycle so a late accept cannot orphan a transfer.
        if (flushM) begin
          state_d = S_IDLE;
        end else begin
          req = 1'b1;
          if (dbus.data_addr_ok) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
          end else begin
            count_en = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall    = ~dbus.data_data_ok;
        count_en = 1'b1;
        if (dbus.data_data_ok) begin
          if (flushM) begin
            state_d = S_IDLE;
          end else if (pipe_stall) begin
            state_d    = S_DONE;
            captured_d = dbus.data_rdata;
            fresh      = 1'b1;
          end else begin
            state_d = S_IDLE;
            fresh   = 1'b1;
          end
        end else if (flushM) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!pipe_stall) state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall    = 1'b1;
        count_en = 1'b1;
        if (dbus.data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (count_en && wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
    bus_err_d = bus_err_q | (count_en && (32'(wait_cnt_d) >= MAX_WAIT));
  end

  always_comb begin
    readdata_d = readdata_q;
    if (fresh && !memwriteM)
      readdata_d = load_extract(memopM, aluoutM[1:0], dbus.data_rdata);
    else if (state_q == S_DONE && !memwriteM)
      readdata_d = load_extract(memopM, aluoutM[1:0], captured_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      captured_q <= '0;
      readdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      captured_q <= captured_d;
      readdata_q <= readdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stallM          = stall;
  assign readdataM       = readdata_d;
  assign bus_err         = bus_err_q;
  assign dbus.data_req   = req;
  assign dbus.data_wr    = memwriteM;
  assign dbus.data_size  = size;
  assign dbus.data_addr  = aluoutM;
  assign dbus.data_wdata = wdata;
  assign dbus.data_wstrb = wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: handshake timing, lane steering, load extension,
// DONE/DRAIN behaviour, reset abandonment and the wait timeout flag.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, flushM, pipe_stall;
  logic [2:0]  memopM;
  logic [31:0] aluoutM, writedataM;
  logic        stallM, adelM, adesM, bus_err;
  logic [31:0] readdataM;
  int          checks = 0;
  int          errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .pipe_stall (pipe_stall),
    .stallM     (stallM),
    .readdataM  (readdataM),
    .adelM      (adelM),
    .adesM      (adesM),
    .bus_err    (bus_err),
    .dbus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    memenM            = 1'b0;
    memwriteM         = 1'b0;
    flushM            = 1'b0;
    pipe_stall        = 1'b0;
    bus.data_addr_ok  = 1'b0;
    bus.data_data_ok  = 1'b0;
  endtask

  task automatic quick_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
    memenM = 1'b1; memwriteM = 1'b0; memopM = op; aluoutM = addr;
    bus.data_addr_ok = 1'b1;
    settle;
    check({tag, "_req"}, bus.data_req, 1);
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    settle;
    check({tag, "_stall"}, stallM, 0);
    check({tag, "_rd"}, readdataM, exp);
    tick;
    idle_inputs;
    settle;
    check({tag, "_hold"}, readdataM, exp);
  endtask

  task automatic quick_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [1:0] size,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
    memenM = 1'b1; memwriteM = 1'b1; memopM = op; aluoutM = addr; writedataM = wd;
    bus.data_addr_ok = 1'b1;
    settle;
    check({tag, "_req"}, bus.data_req, 1);
    check({tag, "_size"}, bus.data_size, size);
    check({tag, "_wdata"}, bus.data_wdata, wdata);
    check({tag, "_wstrb"}, bus.data_wstrb, wstrb);
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    settle;
    check({tag, "_stall"}, stallM, 0);
    tick;
    idle_inputs;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs;
    memopM = 3'b000; aluoutM = '0; writedataM = '0; bus.data_rdata = '0;
    #3;
    check("rst_stall", stallM, 0);
    check("rst_req", bus.data_req, 0);
    check("rst_rd", readdataM, 0);
    check("rst_buserr", bus_err, 0);
    tick;
    rst = 1'b1;
    tick;

    // LB 0x1003, immediate accept, data two cycles later
    memenM = 1'b1; memwriteM = 1'b0; memopM = 3'b011; aluoutM = 32'h0000_1003;
    bus.data_addr_ok = 1'b1;
    settle;
    check("lb_req", bus.data_req, 1);
    check("lb_stall0", stallM, 1);
    check("lb_wstrb", bus.data_wstrb, 4'b0000);
    check("lb_size", bus.data_size, 0);
    check("lb_addr", bus.data_addr, 32'h0000_1003);
    tick;
    bus.data_addr_ok = 1'b0;
    settle;
    check("lb_stall1", stallM, 1);
    check("lb_req1", bus.data_req, 0);
    tick;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF_0000;
    settle;
    check("lb_stall2", stallM, 0);
    check("lb_rd", readdataM, 32'hFFFF_FF80);
    tick;
    idle_inputs;
    settle;
    check("lb_hold", readdataM, 32'hFFFF_FF80);

    // SH 0x2002, accept one cycle late
    memenM = 1'b1; memwriteM = 1'b1; memopM = 3'b001; aluoutM = 32'h0000_2002;
    writedataM = 32'h1234_ABCD;
    settle;
    check("sh_req0", bus.data_req, 1);
    check("sh_wr", bus.data_wr, 1);
    check("sh_size", bus.data_size, 1);
    check("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
    check("sh_wstrb", bus.data_wstrb, 4'b1100);
    tick;
    bus.data_addr_ok = 1'b1;
    settle;
    check("sh_req1", bus.data_req, 1);
    check("sh_stall1", stallM, 1);
    tick;
    bus.data_addr_ok = 1'b0;
    settle;
    check("sh_req2", bus.data_req, 0);
    check("sh_stall2", stallM, 1);
    tick;
    bus.data_data_ok = 1'b1;
    settle;
    check("sh_stall3", stallM, 0);
    tick;
    idle_inputs;
    settle;
    check("sh_rd_hold", readdataM, 32'hFFFF_FF80);

    // misaligned accesses
    memenM = 1'b1; memwriteM = 1'b0; memopM = 3'b000; aluoutM = 32'h0000_0006;
    settle;
    check("lw6_adel", adelM, 1);
    check("lw6_ades", adesM, 0);
    check("lw6_req", bus.data_req, 0);
    check("lw6_stall", stallM, 0);
    memwriteM = 1'b1; aluoutM = 32'h0000_0005;
    settle;
    check("sw5_ades", adesM, 1);
    check("sw5_req", bus.data_req, 0);
    memwriteM = 1'b0; memopM = 3'b001; aluoutM = 32'h0000_0001; flushM = 1'b1;
    settle;
    check("lh1_flush_adel", adelM, 0);
    tick;
    idle_inputs;

    quick_store("sb3", 3'b011, 32'h0000_0003, 32'h0000_00A5, 2'd0, 32'hA5A5_A5A5, 4'b1000);
    quick_store("sw40", 3'b000, 32'h0000_0040, 32'h1122_3344, 2'd2, 32'h1122_3344, 4'b1111);
    quick_store("sh2000", 3'b001, 32'h0000_2000, 32'hFFFF_5678, 2'd1, 32'h5678_5678, 4'b0011);

    quick_load("lh12", 3'b001, 32'h0000_0012, 32'h8001_1234, 32'hFFFF_8001);
    quick_load("lbu21", 3'b100, 32'h0000_0021, 32'h0000_F500, 32'h0000_00F5);
    quick_load("lw24", 3'b000, 32'h0000_0024, 32'hCAFE_F00D, 32'hCAFE_F00D);
    quick_load("lb22", 3'b011, 32'h0000_0022, 32'h007F_0000, 32'h0000_007F);

    // LHU 0x10 completing under pipe_stall -> DONE
    memenM = 1'b1; memwriteM = 1'b0; memopM = 3'b010; aluoutM = 32'h0000_0010;
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000_9ABC;
    pipe_stall = 1'b1;
    settle;
    check("lhu_stall", stallM, 0);
    check("lhu_rd", readdataM, 32'h0000_9ABC);
    tick;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      settle;
      check("done_req", bus.data_req, 0);
      check("done_stall", stallM, 0);
      check("done_rd", readdataM, 32'h0000_9ABC);
      tick;
    end
    pipe_stall = 1'b0;
    settle;
    check("done_exit_rd", readdataM, 32'h0000_9ABC);
    check("done_exit_req", bus.data_req, 0);
    tick;
    idle_inputs;

    // flush in WAIT -> DRAIN, data four cycles later discarded
    memenM = 1'b1; memwriteM = 1'b0; memopM = 3'b000; aluoutM = 32'h0000_0020;
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0; flushM = 1'b1;
    settle;
    check("fl_stall", stallM, 1);
    check("fl_req", bus.data_req, 0);
    tick;
    idle_inputs;
    for (int i = 0; i < 3; i++) begin
      settle;
      check("drain_stall", stallM, 1);
      check("drain_req", bus.data_req, 0);
      tick;
    end
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_5555;
    settle;
    check("drain_ok_stall", stallM, 1);
    check("drain_ok_rd", readdataM, 32'h0000_9ABC);
    tick;
    idle_inputs;
    settle;
    check("drain_idle_stall", stallM, 0);
    check("drain_idle_rd", readdataM, 32'h0000_9ABC);

    // reset mid-transaction, then a fresh request
    memenM = 1'b1; memwriteM = 1'b0; memopM = 3'b000; aluoutM = 32'h0000_0040;
    tick;
    settle;
    rst = 1'b0; memenM = 1'b0;
    #1;
    check("mid_rst_req", bus.data_req, 0);
    check("mid_rst_stall", stallM, 0);
    check("mid_rst_rd", readdataM, 0);
    tick;
    rst = 1'b1;
    memenM = 1'b1;
    settle;
    check("post_rst_req", bus.data_req, 1);
    check("post_rst_stall", stallM, 1);
    tick;
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_F00D;
    settle;
    check("post_rst_rd", readdataM, 32'h0BAD_F00D);
    tick;
    idle_inputs;

    // accept never arrives -> bus_err after 8 cycles in REQ
    memenM = 1'b1; memwriteM = 1'b1; memopM = 3'b000; aluoutM = 32'h0000_0080;
    tick;
    for (int i = 1; i < 8; i++) tick;
    check("berr_before", bus_err, 0);
    tick;
    check("berr_set", bus_err, 1);
    check("berr_noabort", bus.data_req, 1);
    tick;
    tick;
    check("berr_sticky", bus_err, 1);
    memenM = 1'b0;
    rst = 1'b0;
    #1;
    check("berr_clr", bus_err, 0);
    tick;
    rst = 1'b1;
    tick;
    check("berr_stays_clr", bus_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255: bus-wait cycle count at which bus_err sets.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 memenM  in  1  M-stage instruction is a load/store.
REQ-005 memwriteM  in  1  1=store, 0=load.
REQ-006 memopM  in  3  load: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; store: 000 SW, 001 SH, 011 SB.
REQ-007 aluoutM  in  32  effective byte address.
REQ-008 writedataM  in  32  store source register value.
REQ-009 flushM  in  1  cancel the M-stage instruction.
REQ-010 pipe_stall  in  1  pipeline frozen by another source.
REQ-011 stallM  out  1  freeze pipeline at M and earlier stages.
REQ-012 readdataM  out  32  aligned, extended load result.
REQ-013 adelM / adesM  out  1 each  misaligned load / misaligned store.
REQ-014 data_req, data_wr  out  1 each  bus request; 1=write.
REQ-015 data_size  out  2  0 byte, 1 half, 2 word.
REQ-016 data_addr, data_wdata  out  32 each  bus address and write data; data_wstrb  out  4  byte enables.
REQ-017 data_addr_ok, data_data_ok  in  1 each  request accepted; data returned or write done.
REQ-018 data_rdata  in  32  read data.
REQ-019 bus_err  out  1  sticky wait-timeout flag.

Function
REQ-020 valid = memenM & ~flushM & aligned; aligned: word needs addr[1:0]=00, half needs addr[0]=0, byte always.
REQ-021 adelM/adesM = memenM & ~flushM & ~aligned & ~/& memwriteM, combinational; no bus request and no stall for a misaligned access.
REQ-022 FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
REQ-023 IDLE: data_req = valid; stallM = valid; addr_ok same cycle -> WAIT, else valid -> REQ.
REQ-024 REQ: data_req=1, stallM=1; flushM -> IDLE (request withdrawn); addr_ok -> WAIT.
REQ-025 WAIT: data_req=0; stallM = ~data_data_ok; data_ok & flushM -> IDLE, discarding data; data_ok & pipe_stall -> DONE, capturing data; data_ok otherwise -> IDLE; flushM without data_ok -> DRAIN.
REQ-026 DONE: stallM=0, no request, readdataM from captured register; ~pipe_stall -> IDLE.
REQ-027 DRAIN: stallM=1, no request, data discarded; data_ok -> IDLE.
REQ-028 data_ok arrives no earlier than the cycle after addr_ok; data_ok is ignored in IDLE/REQ.
REQ-029 data_addr = aluoutM; data_wr = memwriteM; data_size from memopM; all held stable while data_req=1.
REQ-030 Store data/strobes: SW wdata=wd, wstrb=1111; SH wdata={2{wd[15:0]}}, wstrb=addr[1]?1100:0011; SB wdata={4{wd[7:0]}}, wstrb=0001<<addr[1:0]. Loads drive wstrb=0000.
REQ-031 Load extract from the lane given by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough; applied to data_rdata in the data_ok cycle and to the captured word in DONE.
REQ-032 readdataM is valid only when stallM=0 after a completed load; otherwise it holds its last value.
REQ-033 wait_cnt (8-bit, saturating) clears on entry to REQ/WAIT and increments each cycle in REQ/WAIT/DRAIN; at MAX_WAIT, bus_err sets and stays set until reset; no abort.

Reset
REQ-034 rst low asynchronously forces IDLE, wait_cnt=0, captured=0, bus_err=0, readdataM=0; combinational outputs follow from IDLE.
REQ-035 Reset mid-transaction abandons it; after release, the next valid access issues a fresh request.

Verification
REQ-036 LB at 0x1003, addr_ok immediate, data_ok +2 cycles, rdata=0x80FF_0000 -> wstrb 0000, stallM high 2 cycles, readdataM=0xFFFF_FF80.
REQ-037 SH at 0x2002, wd=0x1234_ABCD, addr_ok +1 cycle -> size 1, wdata 0xABCD_ABCD, wstrb 1100, data_req high 2 cycles.
REQ-038 LW at 0x0006 -> adelM=1, data_req=0, stallM=0.
REQ-039 LHU at 0x10, data_ok with pipe_stall=1 for 3 cycles, rdata=0x0000_9ABC -> DONE holds readdataM=0x0000_9ABC, no second request.
REQ-040 flushM in WAIT, data_ok 4 cycles later -> DRAIN, stallM=1 until data_ok, data discarded, then IDLE.
REQ-041 addr_ok never returned with MAX_WAIT=8 -> bus_err=1 after 8 waiting cycles; bus_err cleared only by rst=0.
